// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the 4-way round-robin arbiter.
// Holds the state encoding, requester count and hold-limit default.
package rr_arbiter4_pkg;

    localparam int unsigned N_REQ        = 4;
    localparam int unsigned IDX_W        = 2;
    localparam int unsigned MAX_HOLD_DEF = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter4_pick.sv
// Combinational round-robin search.
// Returns the first set mask bit at or above start, wrapping around.
module rr_pick
    import rr_arbiter4_pkg::*;
(
    input  logic [N_REQ-1:0] mask,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan four positions from start; the first hit wins.
    always_comb begin
        logic [IDX_W-1:0] j;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = start + IDX_W'(k);
            if (!found && mask[j]) begin
                idx   = j;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a per-owner hold limit.
// Registered one-hot grant, binary select and busy flag.
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] select,
    output logic             busy
);

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    state_t           state, state_n;
    logic [N_REQ-1:0] gnt_n;
    logic [IDX_W-1:0] select_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [7:0]       hold_cnt, hold_n;

    logic [N_REQ-1:0] pick_mask;
    logic [IDX_W-1:0] pick_start;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;

    // The current owner is excluded from the search (gnt is zero in IDLE),
    // so a lone owner at its limit keeps the grant instead of re-arbitrating.
    assign pick_mask  = req & ~gnt;
    assign pick_start = (state == IDLE) ? ptr + 2'd1 : select + 2'd1;

    rr_pick u_pick (
        .mask  (pick_mask),
        .start (pick_start),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign busy = |gnt;

    // State register; reset drops the grant without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            select   <= '0;
            ptr      <= 2'd3;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            select   <= select_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
        end
    end

    // Next-state: hold, saturate, preempt, hand over or go idle.
    always_comb begin
        state_n  = state;
        gnt_n    = gnt;
        select_n = select;
        ptr_n    = ptr;
        hold_n   = hold_cnt;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    state_n  = GRANT;
                    gnt_n    = N_REQ'(1) << pick_idx;
                    select_n = pick_idx;
                    ptr_n    = pick_idx;
                    hold_n   = '0;
                end
            end
            GRANT: begin
                if (req[select] && hold_cnt < HOLD_LIM) begin
                    hold_n = hold_cnt + 8'd1;
                end else if (pick_found) begin
                    gnt_n    = N_REQ'(1) << pick_idx;
                    select_n = pick_idx;
                    ptr_n    = pick_idx;
                    hold_n   = '0;
                end else if (!req[select]) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    hold_n  = '0;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed and random checks for rr_arbiter4.
// Each scenario task compares outputs against hand-computed values.
module tb_rr_arbiter4;

    localparam int MH = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] select;
    logic       busy;

    int checks;
    int errors;

    rr_arbiter4 #(.MAX_HOLD(MH)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .gnt    (gnt),
        .select (select),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL reset_gnt got %b want 0000", gnt);
        end
        checks++;
        if (select !== 2'd0) begin
            errors++;
            $display("FAIL reset_select got %0d want 0", select);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL idle_no_req got %b want 0000", gnt);
        end
    endtask

    task automatic test_hold_limit();
        do_reset();
        req = 4'b1111;
        tick();
        checks++;
        if (gnt !== 4'b0001 || select !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_grant got %b/%0d/%b want 0001/0/1",
                     gnt, select, busy);
        end
        for (int i = 1; i < MH; i++) begin
            tick();
            checks++;
            if (gnt !== 4'b0001) begin
                errors++;
                $display("FAIL hold_cycle%0d got %b want 0001", i, gnt);
            end
        end
        tick();
        checks++;
        if (gnt !== 4'b0010 || select !== 2'd1) begin
            errors++;
            $display("FAIL preempt got %b/%0d want 0010/1", gnt, select);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 4'b0001;
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL b2b_setup got %b want 0001", gnt);
        end
        req = 4'b1000;
        tick();
        checks++;
        if (gnt !== 4'b1000 || select !== 2'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_handover got %b/%0d/%b want 1000/3/1",
                     gnt, select, busy);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        req = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (gnt !== 4'b0100) begin
                errors++;
                $display("FAIL sat_hold%0d got %b want 0100", i, gnt);
            end
        end
        req = 4'b0110;
        tick();
        checks++;
        if (gnt !== 4'b0010 || select !== 2'd1) begin
            errors++;
            $display("FAIL sat_preempt got %b/%0d want 0010/1", gnt, select);
        end
    endtask

    task automatic test_drop_idle();
        do_reset();
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle got %b/%b want 0000/0", gnt, busy);
        end
        checks++;
        if (select !== 2'd2) begin
            errors++;
            $display("FAIL drop_select got %0d want 2", select);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0010;
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL arst_setup got %b want 0010", gnt);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL arst_drop got %b/%b want 0000/0", gnt, busy);
        end
        #1;
        rst = 1'b0;
        req = 4'b0011;
        tick();
        checks++;
        if (gnt !== 4'b0001 || select !== 2'd0) begin
            errors++;
            $display("FAIL arst_regrant got %b/%0d want 0001/0", gnt, select);
        end
    endtask

    task automatic test_ptr_order();
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        req = 4'b1001;
        tick();
        checks++;
        if (gnt !== 4'b1000 || select !== 2'd3) begin
            errors++;
            $display("FAIL ptr_order got %b/%0d want 1000/3", gnt, select);
        end
        req = 4'b0000;
        tick();
        req = 4'b1001;
        tick();
        checks++;
        if (gnt !== 4'b0001 || select !== 2'd0) begin
            errors++;
            $display("FAIL ptr_wrap got %b/%0d want 0001/0", gnt, select);
        end
    endtask

    task automatic test_random();
        int wait_cnt [4];
        logic [3:0] nreq;
        do_reset();
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            nreq = req;
            for (int i = 0; i < 4; i++) begin
                if (req[i] && !gnt[i]) nreq[i] = 1'b1;
                else if (req[i]) nreq[i] = ($urandom_range(0, 5) != 0);
                else nreq[i] = ($urandom_range(0, 1) == 1);
            end
            req = nreq;
            tick();
            checks++;
            if (!$onehot0(gnt) || busy !== (|gnt)) begin
                errors++;
                $display("FAIL rnd_onehot cyc%0d got %b/%b", c, gnt, busy);
            end
            if (gnt != 4'b0000) begin
                checks++;
                if ((4'b0001 << select) !== gnt) begin
                    errors++;
                    $display("FAIL rnd_select cyc%0d got %0d gnt %b",
                             c, select, gnt);
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (req[i] && !gnt[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                checks++;
                if (wait_cnt[i] > 3 * MH + 3) begin
                    errors++;
                    $display("FAIL rnd_starve req%0d waited %0d max %0d",
                             i, wait_cnt[i], 3 * MH + 3);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        req    = 4'b0000;
        test_reset();
        test_hold_limit();
        test_back_to_back();
        test_saturate();
        test_drop_idle();
        test_async_reset();
        test_ptr_order();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
